// File: rtl/disp_scan_ctrl.sv
// Latches a signed ALU result, converts it to tens/units BCD by repeated
// subtraction, and scans sign/tens/units displays with active-low anodes.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int N_DIG       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [6:0]  mag_in,
    input  logic        neg_in,
    input  logic [1:0]  oper_in,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  D,
    output logic [3:0]  tens,
    output logic        Flag,
    output logic [1:0]  oper,
    output logic [31:0] deco,
    output logic [2:0]  anode
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [1:0] DIG_LAST = 2'(N_DIG - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state;
    logic [6:0]    work;
    logic [3:0]    tcnt;
    logic          neg_r;
    logic [1:0]    oper_r;
    logic [3:0]    units_r;

    logic [PW-1:0] pre;
    logic [1:0]    dsel;
    logic [1:0]    dnext;
    logic          wrap;

    assign deco = {30'd0, dsel};
    assign wrap = (pre == PRE_LAST);

    always_comb begin
        dnext = dsel;
        if (wrap)
            dnext = (dsel == DIG_LAST) ? 2'd0 : dsel + 2'd1;
    end

    // Scan runs free of the converter; D follows the display being selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre   <= '0;
            dsel  <= 2'd0;
            anode <= 3'b110;
            D     <= 4'd0;
        end else begin
            pre  <= wrap ? '0 : pre + PW'(1);
            dsel <= dnext;
            case (dnext)
                2'd1:    begin anode <= 3'b101; D <= tens;    end
                2'd2:    begin anode <= 3'b011; D <= units_r; end
                default: begin anode <= 3'b110; D <= 4'd0;    end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            work    <= 7'd0;
            tcnt    <= 4'd0;
            neg_r   <= 1'b0;
            oper_r  <= 2'd0;
            units_r <= 4'd0;
            tens    <= 4'd0;
            Flag    <= 1'b0;
            oper    <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        work   <= (mag_in > 7'd99) ? 7'd99 : mag_in;
                        ovf    <= (mag_in > 7'd99);
                        neg_r  <= neg_in;
                        oper_r <= oper_in;
                        tcnt   <= 4'd0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    if (work >= 7'd10) begin
                        work <= work - 7'd10;
                        tcnt <= tcnt + 4'd1;
                    end else begin
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    tens    <= tcnt;
                    units_r <= work[3:0];
                    Flag    <= neg_r;
                    oper    <= oper_r;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
